pipe_control: RTL and testbench
===============================

# pipe_control

Parametrised pipeline hazard controller for the NaiveMIPS datapath. It generalises the fixed 5-stage stall/flush decoder to `STAGES` pipeline registers with per-register stall requests and resolves them by priority into hold/bubble controls. It adds a registered exception sequencer that drains an outstanding data-bus transaction before flushing and redirecting. It sits beside the datapath, driving every pipeline register's stall/flush, the PC, and the ibus/dbus pause inputs.

## Interface
- `STAGES`, 4: number of pipeline registers after the PC; register 0 is IF/ID, register `STAGES-1` is the last (MM/WB at 4).
- `WDOG_LIMIT`, 1024: consecutive frozen cycles before the watchdog fires; used only with the watchdog macro.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `stall_req` in `STAGES`: bit k means the consumer of register k cannot accept new data this cycle.
- `except` in 1: exception detected; level, sampled each cycle.
- `dbus_busy` in 1: a data-bus transaction is outstanding.
- `stage_stall` out `STAGES`: hold register k.
- `stage_flush` out `STAGES`: load a bubble into register k.
- `pc_stall` out 1: hold the PC.
- `pc_redirect` out 1: load the exception handler address into the PC.
- `ibus_pause` out 1: do not issue a new fetch.
- `dbus_pause` out 1: do not issue a new data request.
- `seq_state` out 2: sequencer state, for debug (RUN=0, DRAIN=1, FLUSH=2).
- `wdog_timeout` out 1: sticky watchdog flag.

## Operation
- Priority resolution happens in RUN with `except`=0.
  - h = highest set index of `stall_req`.
  - `stage_stall[j]`=1 for all j<h.
  - If h<STAGES-1: `stage_flush[h]`=1 (bubble).
  - If h=STAGES-1: `stage_stall[h]`=1 and there is no bubble.
  - `pc_stall`=1 when any request is set.
  - With no request set, all outputs are 0.
- `ibus_pause` = `|stall_req[STAGES-1:1]` OR state≠RUN OR `except`. `stall_req[0]` is the fetch's own wait and does not pause it.
- `dbus_pause`=1 only in FLUSH.
- Sequencer (2-bit, registered):
  - **RUN**, `except`=1:
    - Same cycle: all `stage_stall`=1 and `pc_stall`=1, freezing the pipe. `stall_req` is ignored.
    - Next state is DRAIN if `dbus_busy`, else FLUSH.
  - **DRAIN**:
    - All stalls are 1 and all flushes are 0; `except` and `stall_req` are ignored.
    - Move to FLUSH in the first cycle `dbus_busy`=0, sampled at the edge.
  - **FLUSH**, exactly one cycle:
    - All `stage_flush`=1, all `stage_stall`=0, `pc_stall`=0, `pc_redirect`=1.
    - Next state is RUN unconditionally.
- Simultaneous events:
  - An `except` arriving during DRAIN or FLUSH is dropped; the first exception wins.
  - `except` in RUN overrides every `stall_req`.
  - Flush always overrides stall.
- While `rst_n`=0, every output is 0 regardless of inputs, and `seq_state`=RUN.
- Reset mid-DRAIN or mid-FLUSH aborts the sequence. After release the block is in RUN with no pending exception.

## Timing
- Priority path: purely combinational from `stall_req`/`except` to outputs, zero latency.
- Exception with `dbus_busy`=0: freeze at cycle t, flush and redirect at t+1, RUN at t+2.
- Exception with `dbus_busy` high until and including cycle t+n: DRAIN covers t+1…t+n+1, FLUSH at t+n+2.
- `seq_state` and `wdog_timeout` are registered. All other outputs are Mealy.

## Configuration
- Macro: `PIPE_CONTROL_WATCHDOG_EN`.
- When defined:
  - A counter increments each cycle `pc_stall`=1 and clears on any cycle `pc_stall`=0.
  - It saturates at `WDOG_LIMIT`.
  - `wdog_timeout` is set on the edge where the count reaches `WDOG_LIMIT` and stays set until reset.
  - Counter width is `$clog2(WDOG_LIMIT+1)`.
- When undefined: there is no counter, `wdog_timeout` is tied to 0, and `WDOG_LIMIT` is unused.

## Structure
- `pipe_control_pkg` holds:
  - the `seq_state_t` enum (RUN/DRAIN/FLUSH, 2 bits);
  - default `STAGES` and `WDOG_LIMIT` constants.
- The sub-module `pipe_control_wdog` holds the counter and sticky flag. It is instantiated only under the macro.
- Priority encoding and the sequencer stay in the top module.

## Test plan
(All scenarios use `STAGES`=4.)
- `stall_req`=4'b0010 in RUN → `stage_stall`=0001, `stage_flush`=0010, `pc_stall`=1, `ibus_pause`=1.
- `stall_req`=4'b1011 → `stage_stall`=1111, `stage_flush`=0000. Then `stall_req`=4'b0001 → `stage_stall`=0000, `stage_flush`=0001, `ibus_pause`=0.
- `except`=1 at t with `dbus_busy`=0 → t: `stage_stall`=1111. t+1: `stage_flush`=1111, `pc_redirect`=1, `dbus_pause`=1. t+2: `seq_state`=RUN.
- `except` at t with `dbus_busy` high for t…t+3, plus a second `except` at t+2 → DRAIN t+1…t+4, a single FLUSH at t+5, no second FLUSH.
- Deassert `rst_n` during DRAIN → outputs 0 immediately. After release, `seq_state`=RUN and `stall_req`=0 gives all-zero outputs.
- With the macro defined and `WDOG_LIMIT`=8, hold `stall_req`=4'b1000 → `wdog_timeout` rises after 8 frozen cycles. It stays 1 after `stall_req` clears and drops only on reset. With the macro undefined it stays 0.

Source files
------------

// File: rtl/pipe_control_pkg.sv
// pipe_control_pkg: shared types and default parameters for the pipeline
// hazard controller (pipe_control) and its optional watchdog.
package pipe_control_pkg;

    // Exception sequencer states; encoding is visible on the seq_state debug port.
    typedef enum logic [1:0] {
        SEQ_RUN   = 2'd0,
        SEQ_DRAIN = 2'd1,
        SEQ_FLUSH = 2'd2
    } seq_state_t;

    localparam int DEFAULT_STAGES     = 4;
    localparam int DEFAULT_WDOG_LIMIT = 1024;

endpackage

// File: rtl/pipe_control_wdog.sv
// pipe_control_wdog: counts consecutive cycles with the PC held and raises a
// sticky timeout flag once the count reaches WDOG_LIMIT. Only instantiated
// by pipe_control when PIPE_CONTROL_WATCHDOG_EN is defined.
module pipe_control_wdog
    import pipe_control_pkg::*;
#(
    parameter int WDOG_LIMIT = DEFAULT_WDOG_LIMIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pc_stall,
    output logic wdog_timeout
);

    localparam int              CNT_W = $clog2(WDOG_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WDOG_LIMIT);

    logic [CNT_W-1:0] count_reg;
    logic             timeout_reg;

    // Saturating frozen-cycle counter; the flag latches on the edge the count hits the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg   <= '0;
            timeout_reg <= 1'b0;
        end else begin
            if (!pc_stall) begin
                count_reg <= '0;
            end else if (count_reg != LIMIT) begin
                count_reg <= count_reg + CNT_W'(1);
            end
            if (pc_stall && (count_reg == LIMIT - CNT_W'(1))) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    assign wdog_timeout = timeout_reg;

endmodule

// File: rtl/pipe_control.sv
// pipe_control: pipeline hazard controller. Resolves per-register stall
// requests into hold/bubble controls and sequences exceptions
// (freeze -> optional data-bus drain -> flush + redirect).
// Optional feature: define PIPE_CONTROL_WATCHDOG_EN to add the frozen-PC
// watchdog (pipe_control_wdog); otherwise wdog_timeout is tied low.
module pipe_control
    import pipe_control_pkg::*;
#(
    parameter int STAGES     = DEFAULT_STAGES,
    parameter int WDOG_LIMIT = DEFAULT_WDOG_LIMIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [STAGES-1:0] stall_req,
    input  logic              except,
    input  logic              dbus_busy,
    output logic [STAGES-1:0] stage_stall,
    output logic [STAGES-1:0] stage_flush,
    output logic              pc_stall,
    output logic              pc_redirect,
    output logic              ibus_pause,
    output logic              dbus_pause,
    output logic [1:0]        seq_state,
    output logic              wdog_timeout
);

    seq_state_t        state_reg;
    logic [STAGES-1:0] prio_stall;
    logic [STAGES-1:0] prio_flush;

    // Priority encoding: a register is held when any later register requests a
    // stall; the highest requester gets a bubble, except the last register,
    // which has nothing behind it to absorb a bubble and is simply held.
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_prio
            if (gi == STAGES - 1) begin : g_last
                assign prio_stall[gi] = stall_req[gi];
                assign prio_flush[gi] = 1'b0;
            end else begin : g_mid
                logic req_above;
                assign req_above      = |stall_req[STAGES-1:gi+1];
                assign prio_stall[gi] = req_above;
                assign prio_flush[gi] = stall_req[gi] & ~req_above;
            end
        end
    endgenerate

    // Exception sequencer: a new exception is only accepted in RUN, so the first one wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= SEQ_RUN;
        end else begin
            case (state_reg)
                SEQ_RUN: begin
                    if (except) begin
                        state_reg <= dbus_busy ? SEQ_DRAIN : SEQ_FLUSH;
                    end
                end
                SEQ_DRAIN: begin
                    if (!dbus_busy) begin
                        state_reg <= SEQ_FLUSH;
                    end
                end
                default: state_reg <= SEQ_RUN;
            endcase
        end
    end

    // Output decode (Mealy); everything is forced low while reset is asserted.
    always_comb begin
        stage_stall = '0;
        stage_flush = '0;
        pc_stall    = 1'b0;
        pc_redirect = 1'b0;
        ibus_pause  = 1'b0;
        dbus_pause  = 1'b0;
        if (rst_n) begin
            case (state_reg)
                SEQ_RUN: begin
                    if (except) begin
                        stage_stall = '1;
                        pc_stall    = 1'b1;
                    end else begin
                        stage_stall = prio_stall;
                        stage_flush = prio_flush;
                        pc_stall    = |stall_req;
                    end
                end
                SEQ_DRAIN: begin
                    stage_stall = '1;
                    pc_stall    = 1'b1;
                end
                SEQ_FLUSH: begin
                    stage_flush = '1;
                    pc_redirect = 1'b1;
                    dbus_pause  = 1'b1;
                end
                default: ;
            endcase
            // stall_req[0] is the fetch's own wait, so it does not pause fetching.
            ibus_pause = (|stall_req[STAGES-1:1]) | (state_reg != SEQ_RUN) | except;
        end
    end

    assign seq_state = state_reg;

`ifdef PIPE_CONTROL_WATCHDOG_EN
    pipe_control_wdog #(
        .WDOG_LIMIT(WDOG_LIMIT)
    ) u_wdog (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_stall    (pc_stall),
        .wdog_timeout(wdog_timeout)
    );
`else
    logic unused_wdog_limit;
    assign unused_wdog_limit = (WDOG_LIMIT > 0);
    assign wdog_timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_control.sv
// tb_pipe_control: directed bench for pipe_control (STAGES=4, WDOG_LIMIT=8)
// with a behavioural reference model checked every cycle, plus literal
// expectations for the documented scenarios.
module tb_pipe_control;

    localparam int S  = 4;
    localparam int WL = 8;
`ifdef PIPE_CONTROL_WATCHDOG_EN
    localparam logic WD_ON = 1'b1;
`else
    localparam logic WD_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [S-1:0] stall_req;
    logic         except;
    logic         dbus_busy;
    logic [S-1:0] stage_stall;
    logic [S-1:0] stage_flush;
    logic         pc_stall;
    logic         pc_redirect;
    logic         ibus_pause;
    logic         dbus_pause;
    logic [1:0]   seq_state;
    logic         wdog_timeout;

    int n_pass  = 0;
    int n_total = 0;
    bit ck_en   = 1'b0;

    always #5 clk = ~clk;

    pipe_control #(
        .STAGES    (S),
        .WDOG_LIMIT(WL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_req   (stall_req),
        .except      (except),
        .dbus_busy   (dbus_busy),
        .stage_stall (stage_stall),
        .stage_flush (stage_flush),
        .pc_stall    (pc_stall),
        .pc_redirect (pc_redirect),
        .ibus_pause  (ibus_pause),
        .dbus_pause  (dbus_pause),
        .seq_state   (seq_state),
        .wdog_timeout(wdog_timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // m_phase: 0 = normal running, 1 = waiting for dbus, 2 = flush cycle
    int   m_phase;
    int   m_frozen;
    logic m_timeout;
    int   e_h;
    logic [S-1:0] e_stall, e_flush;
    logic e_pcs, e_red, e_ib, e_db;

    always_comb begin
        e_stall = '0;
        e_flush = '0;
        e_pcs   = 1'b0;
        e_red   = 1'b0;
        e_ib    = 1'b0;
        e_db    = 1'b0;
        e_h     = -1;
        if (rst_n) begin
            if (m_phase == 0 && !except) begin
                for (int k = 0; k < S; k++) if (stall_req[k]) e_h = k;
                if (e_h >= 0) begin
                    e_pcs = 1'b1;
                    if (e_h == S - 1) begin
                        e_stall = '1;
                    end else begin
                        e_stall = S'((1 << e_h) - 1);
                        e_flush = S'(1 << e_h);
                    end
                end
            end else if (m_phase == 0 || m_phase == 1) begin
                e_stall = '1;
                e_pcs   = 1'b1;
            end else begin
                e_flush = '1;
                e_red   = 1'b1;
                e_db    = 1'b1;
            end
            e_ib = (stall_req[S-1:1] != 0) || (m_phase != 0) || except;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase   <= 0;
            m_frozen  <= 0;
            m_timeout <= 1'b0;
        end else begin
            case (m_phase)
                0:       if (except) m_phase <= dbus_busy ? 1 : 2;
                1:       if (!dbus_busy) m_phase <= 2;
                default: m_phase <= 0;
            endcase
            if (e_pcs) begin
                if (m_frozen < WL) m_frozen <= m_frozen + 1;
                if (m_frozen + 1 == WL) m_timeout <= 1'b1;
            end else begin
                m_frozen <= 0;
            end
        end
    end

    logic [14:0] out_vec, exp_vec;
    assign out_vec = {stage_stall, stage_flush, pc_stall, pc_redirect, ibus_pause,
                      dbus_pause, seq_state, wdog_timeout};
    assign exp_vec = {e_stall, e_flush, e_pcs, e_red, e_ib, e_db, 2'(m_phase),
                      m_timeout & WD_ON};

    // Per-cycle comparison against the model, on the falling edge.
    always @(negedge clk) begin
        if (ck_en) check("cycle_model", 32'(out_vec), 32'(exp_vec));
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [S-1:0] req, input logic exc, input logic busy);
        @(posedge clk);
        #1;
        stall_req = req;
        except    = exc;
        dbus_busy = busy;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        stall_req = 4'b1010;
        except    = 1'b1;
        dbus_busy = 1'b1;
        ck_en     = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", 32'(out_vec), 32'h0);

        @(posedge clk);
        #1;
        rst_n = 1'b1; stall_req = '0; except = 1'b0; dbus_busy = 1'b0;
        settle();
        check("idle_outputs", 32'(out_vec), 32'h0);

        // Single mid-pipe request
        drive(4'b0010, 1'b0, 1'b0); settle();
        check("r0010_stall", 32'(stage_stall), 32'h1);
        check("r0010_flush", 32'(stage_flush), 32'h2);
        check("r0010_pc_ib", 32'({pc_stall, ibus_pause}), 32'h3);
        drive(4'b0000, 1'b0, 1'b0);

        // Highest request at last register, then fetch-only wait
        drive(4'b1011, 1'b0, 1'b0); settle();
        check("r1011_stall", 32'(stage_stall), 32'hF);
        check("r1011_flush", 32'(stage_flush), 32'h0);
        drive(4'b0001, 1'b0, 1'b0); settle();
        check("r0001_stall", 32'(stage_stall), 32'h0);
        check("r0001_flush", 32'(stage_flush), 32'h1);
        check("r0001_ib_pc", 32'({ibus_pause, pc_stall}), 32'h1);
        drive(4'b0000, 1'b0, 1'b0);

        // Exception, data bus idle
        drive(4'b0100, 1'b1, 1'b0); settle();
        check("exc_t_stall", 32'(stage_stall), 32'hF);
        check("exc_t_flush", 32'(stage_flush), 32'h0);
        drive(4'b0000, 1'b0, 1'b0); settle();
        check("exc_t1_flush", 32'(stage_flush), 32'hF);
        check("exc_t1_redir_dbp", 32'({pc_redirect, dbus_pause, pc_stall}), 32'h6);
        check("exc_t1_state", 32'(seq_state), 32'h2);
        drive(4'b0000, 1'b0, 1'b0); settle();
        check("exc_t2_state", 32'(seq_state), 32'h0);

        // Exception with drain, second exception ignored
        drive(4'b0000, 1'b1, 1'b1); settle();
        check("drain_t_state", 32'(seq_state), 32'h0);
        drive(4'b0000, 1'b0, 1'b1); settle();
        check("drain_t1_state", 32'(seq_state), 32'h1);
        drive(4'b0010, 1'b1, 1'b1); settle();
        check("drain_t2_state", 32'(seq_state), 32'h1);
        check("drain_t2_ctrl", 32'({stage_stall, stage_flush}), 32'hF0);
        drive(4'b0000, 1'b0, 1'b1); settle();
        check("drain_t3_state", 32'(seq_state), 32'h1);
        drive(4'b0000, 1'b0, 1'b0); settle();
        check("drain_t4_state", 32'(seq_state), 32'h1);
        drive(4'b0000, 1'b0, 1'b0); settle();
        check("drain_t5_state", 32'(seq_state), 32'h2);
        check("drain_t5_redir", 32'(pc_redirect), 32'h1);
        drive(4'b0000, 1'b0, 1'b0); settle();
        check("drain_t6_state", 32'(seq_state), 32'h0);
        drive(4'b0000, 1'b0, 1'b0); settle();
        check("drain_t7_no_flush", 32'({seq_state, pc_redirect}), 32'h0);

        // Reset during DRAIN
        drive(4'b0000, 1'b1, 1'b1);
        drive(4'b0000, 1'b0, 1'b1); settle();
        check("rst_pre_state", 32'(seq_state), 32'h1);
        rst_n = 1'b0; stall_req = 4'b1111; except = 1'b1;
        #1;
        check("rst_mid_drain", 32'(out_vec), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; stall_req = '0; except = 1'b0; dbus_busy = 1'b0;
        settle();
        check("rst_release", 32'(out_vec), 32'h0);
        drive(4'b0000, 1'b0, 1'b0); settle();
        check("rst_no_pending", 32'(out_vec), 32'h0);

        // Watchdog: hold the last register frozen
        drive(4'b1000, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) drive(4'b1000, 1'b0, 1'b0);
        settle();
        check("wdog_7_cycles", 32'(wdog_timeout), 32'h0);
        drive(4'b1000, 1'b0, 1'b0); settle();
        check("wdog_8_cycles", 32'(wdog_timeout), 32'(WD_ON));
        drive(4'b0000, 1'b0, 1'b0);
        drive(4'b0000, 1'b0, 1'b0); settle();
        check("wdog_sticky", 32'(wdog_timeout), 32'(WD_ON));
        rst_n = 1'b0;
        #1;
        check("wdog_reset", 32'(wdog_timeout), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        settle();

        ck_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
